// File: rtl/kamus_if_stage.sv
// kamus_if_stage: instruction fetch stage with req/gnt/rvalid memory port, in-order PC queue
// and a DEPTH-entry instruction FIFO toward the decoder; redirects flush and drain stale responses.
module kamus_if_stage #(
  parameter int                      PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC = '0,
  parameter int                      DEPTH    = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [31:0]         imem_rdata_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
  output logic [31:0]         instr_o,
  output logic [PC_WIDTH-1:0] pc_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [CW-1:0]         outst_q, outst_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d, pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [PC_WIDTH-1:0]   pq_q [DEPTH];
  logic [PC_WIDTH-1:0]   pq_d [DEPTH];
  logic [PC_WIDTH-1:0]   fp_q [DEPTH];
  logic [PC_WIDTH-1:0]   fp_d [DEPTH];
  logic [31:0]           fi_q [DEPTH];
  logic [31:0]           fi_d [DEPTH];
  logic [31:0]           last_instr_q, last_instr_d;
  logic [PC_WIDTH-1:0]   last_pc_q, last_pc_d;
  logic                  gnt_ok, rv, push, pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    disc_d       = disc_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    pq_wr_d      = pq_wr_q;
    pq_rd_d      = pq_rd_q;
    pq_d         = pq_q;
    fp_d         = fp_q;
    fi_d         = fi_q;
    last_instr_d = last_instr_q;
    last_pc_d    = last_pc_q;
    imem_req_o   = state_q == FETCH && ({1'b0, outst_q} + {1'b0, cnt_q} < (CW+1)'(DEPTH));
    gnt_ok       = imem_req_o & imem_gnt_i;
    rv           = imem_rvalid_i && outst_q != '0;
    push         = rv && disc_q == '0 && state_q == FETCH && !redirect_i;
    pop          = cnt_q != '0 && instr_ready_i && !redirect_i;
    outst_d      = outst_q + CW'(gnt_ok) - CW'(rv);
    cnt_d        = redirect_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    if (gnt_ok) begin
      pq_d[pq_wr_q] = pc_q;
      pq_wr_d       = inc(pq_wr_q);
      pc_d          = pc_q + PC_WIDTH'(4);
    end
    if (rv) pq_rd_d = inc(pq_rd_q);
    if (rv && disc_q != '0) disc_d = disc_q - CW'(1);
    if (push) begin
      fi_d[wr_q] = imem_rdata_i;
      fp_d[wr_q] = pq_q[pq_rd_q];
      wr_d       = inc(wr_q);
    end
    if (pop) begin
      last_instr_d = fi_q[rd_q];
      last_pc_d    = fp_q[rd_q];
      rd_d         = inc(rd_q);
    end
    // A flush discards every request still in flight, including one granted this cycle
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~PC_WIDTH'(3);
      wr_d = '0;
      rd_d = '0;
      if (state_q == FETCH) disc_d = outst_d;
    end
    state_d = state_q == BOOT  ? FETCH :
              state_q == DRAIN ? (disc_d == '0 ? FETCH : DRAIN) :
              (redirect_i && outst_d != '0) ? DRAIN : FETCH;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      outst_q      <= '0;
      disc_q       <= '0;
      cnt_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      pq_wr_q      <= '0;
      pq_rd_q      <= '0;
      pq_q         <= '{default: '0};
      fp_q         <= '{default: '0};
      fi_q         <= '{default: '0};
      last_instr_q <= NOP;
      last_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      outst_q      <= outst_d;
      disc_q       <= disc_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      pq_wr_q      <= pq_wr_d;
      pq_rd_q      <= pq_rd_d;
      pq_q         <= pq_d;
      fp_q         <= fp_d;
      fi_q         <= fi_d;
      last_instr_q <= last_instr_d;
      last_pc_q    <= last_pc_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign instr_valid_o = cnt_q != '0;
  assign instr_o       = instr_valid_o ? fi_q[rd_q] : last_instr_q;
  assign pc_o          = instr_valid_o ? fp_q[rd_q] : last_pc_q;

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> outst_q != '0);
endmodule
